// File: rtl/button_sevseg_io_if.sv
// Avalon-MM slave bus bundle for button_sevseg_io: word address, read/write strobes, data.
// Zero wait states, so there is no waitrequest; readdata is valid one cycle after the read strobe.
interface button_sevseg_io_if;
  logic [3:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/button_sevseg_io.sv
// Button conditioner (sync, debounce, press capture, maskable irq) plus seven-segment digit registers.
// Latency: pin to STATE/EDGE DEBOUNCE_CYCLES+2 edges, readdata/segments 1 cycle; no backpressure.
module button_sevseg_io #(
  parameter int N_BUTTONS       = 5,
  parameter int N_DIGITS        = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BTN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW  = 1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  button_sevseg_io_if.slave       avs,
  output logic                    irq,
  input  logic [N_BUTTONS-1:0]    button_export,
  output logic [7*N_DIGITS-1:0]   sevseg_export
);

  localparam int                   CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]        CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_BUTTONS-1:0] BTN_IDLE = (BTN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [3:0]           A_STATE  = 4'd0;
  localparam logic [3:0]           A_EDGE   = 4'd1;
  localparam logic [3:0]           A_MASK   = 4'd2;
  localparam logic [3:0]           A_MODE   = 4'd3;

  logic [N_BUTTONS-1:0]  r_sync1;
  logic [N_BUTTONS-1:0]  r_sync2;
  logic [N_BUTTONS-1:0]  r_stable;
  logic [CW-1:0]         r_cnt [N_BUTTONS];
  logic [N_BUTTONS-1:0]  r_edge;
  logic [N_BUTTONS-1:0]  r_mask;
  logic [N_DIGITS-1:0]   r_mode;
  logic [7:0]            r_digit [N_DIGITS];
  logic [31:0]           r_rdata;
  logic                  r_irq;
  logic [7*N_DIGITS-1:0] r_seg;

  logic [N_BUTTONS-1:0]  w_mismatch;
  logic [N_BUTTONS-1:0]  w_accept;
  logic [N_BUTTONS-1:0]  w_press;
  logic [N_BUTTONS-1:0]  w_state;
  logic [N_BUTTONS-1:0]  w_w1c;
  logic [31:0]           w_rdata;
  logic [7*N_DIGITS-1:0] w_seg_nxt;
  logic [6:0]            w_pat;
  logic                  w_unused;

  assign w_unused      = &{1'b0, avs.avs_writedata[31:8]};
  assign irq           = r_irq;
  assign avs.avs_readdata = r_rdata;
  assign sevseg_export = r_seg;

  function automatic logic [6:0] f_font(input logic [3:0] v);
    case (v)
      4'h0: f_font = 7'h3F;
      4'h1: f_font = 7'h06;
      4'h2: f_font = 7'h5B;
      4'h3: f_font = 7'h4F;
      4'h4: f_font = 7'h66;
      4'h5: f_font = 7'h6D;
      4'h6: f_font = 7'h7D;
      4'h7: f_font = 7'h07;
      4'h8: f_font = 7'h7F;
      4'h9: f_font = 7'h6F;
      4'hA: f_font = 7'h77;
      4'hB: f_font = 7'h7C;
      4'hC: f_font = 7'h39;
      4'hD: f_font = 7'h5E;
      4'hE: f_font = 7'h79;
      default: f_font = 7'h71;
    endcase
  endfunction

  always_comb begin
    w_mismatch = '0;
    w_accept   = '0;
    w_state    = (BTN_ACTIVE_LOW != 0) ? ~r_stable : r_stable;
    for (int i = 0; i < N_BUTTONS; i++) begin
      w_mismatch[i] = (r_sync2[i] != r_stable[i]);
      w_accept[i]   = w_mismatch[i] && (r_cnt[i] == CNT_LAST);
    end
    // an accepted level that differs from the idle level is a press
    w_press = w_accept & (r_sync2 ^ BTN_IDLE);
    w_w1c   = (avs.avs_write && (avs.avs_address == A_EDGE)) ?
              avs.avs_writedata[N_BUTTONS-1:0] : '0;
  end

  always_comb begin
    w_rdata = '0;
    case (avs.avs_address)
      A_STATE: w_rdata[N_BUTTONS-1:0] = w_state;
      A_EDGE:  w_rdata[N_BUTTONS-1:0] = r_edge;
      A_MASK:  w_rdata[N_BUTTONS-1:0] = r_mask;
      A_MODE:  w_rdata[N_DIGITS-1:0]  = r_mode;
      default: begin
        for (int d = 0; d < N_DIGITS; d++) begin
          if (avs.avs_address == 4'(4 + d)) w_rdata[7:0] = r_digit[d];
        end
      end
    endcase
  end

  always_comb begin
    w_seg_nxt = '0;
    w_pat     = '0;
    for (int d = 0; d < N_DIGITS; d++) begin
      if (r_digit[d][7])  w_pat = 7'h00;
      else if (r_mode[d]) w_pat = r_digit[d][6:0];
      else                w_pat = f_font(r_digit[d][3:0]);
      w_seg_nxt[7*d +: 7] = (SEG_ACTIVE_LOW != 0) ? ~w_pat : w_pat;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync1  <= BTN_IDLE;
      r_sync2  <= BTN_IDLE;
      r_stable <= BTN_IDLE;
      r_edge   <= '0;
      for (int i = 0; i < N_BUTTONS; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= button_export;
      r_sync2 <= r_sync1;
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (w_accept[i]) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else if (w_mismatch[i]) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end else begin
          r_cnt[i] <= '0;
        end
      end
      // a new press in the same cycle as its W1C keeps the bit set
      r_edge <= (r_edge & ~w_w1c) | w_press;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_mask  <= '0;
      r_mode  <= '0;
      r_rdata <= '0;
      r_irq   <= 1'b0;
      r_seg   <= (SEG_ACTIVE_LOW != 0) ? '1 : '0;
      for (int d = 0; d < N_DIGITS; d++) r_digit[d] <= 8'h80;
    end else begin
      r_irq <= |(r_edge & r_mask);
      r_seg <= w_seg_nxt;
      if (avs.avs_read) r_rdata <= w_rdata;
      if (avs.avs_write) begin
        if (avs.avs_address == A_MASK) r_mask <= avs.avs_writedata[N_BUTTONS-1:0];
        if (avs.avs_address == A_MODE) r_mode <= avs.avs_writedata[N_DIGITS-1:0];
        for (int d = 0; d < N_DIGITS; d++) begin
          if (avs.avs_address == 4'(4 + d)) r_digit[d] <= avs.avs_writedata[7:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_button_sevseg_io.sv
// Bench for button_sevseg_io: directed scenarios plus random pins/bus traffic against a register-level model.
module tb_button_sevseg_io;
  localparam int NB = 5;
  localparam int ND = 6;
  localparam int DC = 4;
  localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic              clk_clk = 1'b0;
  logic              reset_reset;
  logic              irq;
  logic [NB-1:0]     button_export;
  logic [7*ND-1:0]   sevseg_export;

  button_sevseg_io_if bus();

  button_sevseg_io #(
    .N_BUTTONS(NB), .N_DIGITS(ND), .DEBOUNCE_CYCLES(DC),
    .BTN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .avs(bus),
    .irq(irq),
    .button_export(button_export),
    .sevseg_export(sevseg_export)
  );

  always #5 clk_clk = ~clk_clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: pin samples per edge (oldest first); a level is accepted once the
  // DC samples that reached the debouncer all disagree with the stable level.
  logic [NB-1:0]   m_q [DC+1];
  logic [NB-1:0]   m_stable;
  logic [NB-1:0]   m_edge;
  logic [NB-1:0]   m_mask;
  logic [ND-1:0]   m_mode;
  logic [7:0]      m_dig [ND];
  logic            m_irq;
  logic [31:0]     m_rdata;
  logic [7*ND-1:0] m_seg;

  task automatic m_reset();
    for (int j = 0; j <= DC; j++) m_q[j] = '1;
    m_stable = '1;
    m_edge   = '0;
    m_mask   = '0;
    m_mode   = '0;
    for (int d = 0; d < ND; d++) m_dig[d] = 8'h80;
    m_irq    = 1'b0;
    m_rdata  = '0;
    m_seg    = '1;
  endtask

  function automatic logic [31:0] m_regval(input int a);
    logic [31:0] v;
    v = '0;
    if (a == 0)      v[NB-1:0] = ~m_stable;
    else if (a == 1) v[NB-1:0] = m_edge;
    else if (a == 2) v[NB-1:0] = m_mask;
    else if (a == 3) v[ND-1:0] = m_mode;
    else if (a >= 4 && a < 4 + ND) v[7:0] = m_dig[a-4];
    return v;
  endfunction

  function automatic logic [7*ND-1:0] m_segs();
    logic [7*ND-1:0] s;
    logic [6:0] lit;
    s = '0;
    for (int d = 0; d < ND; d++) begin
      if (m_dig[d][7])  lit = 7'h00;
      else if (m_mode[d]) lit = m_dig[d][6:0];
      else              lit = FONT[m_dig[d][3:0]];
      s[7*d +: 7] = ~lit;
    end
    return s;
  endfunction

  task automatic tick();
    logic [NB-1:0] acc, press, w1c;
    logic [7*ND-1:0] nseg;
    logic nirq;
    int a;
    @(posedge clk_clk);
    if (reset_reset) begin
      m_reset();
    end else begin
      a = int'(bus.avs_address);
      acc = '1;
      for (int i = 0; i < NB; i++)
        for (int j = 0; j < DC; j++)
          if (m_q[j][i] == m_stable[i]) acc[i] = 1'b0;
      press = acc & m_stable;
      if (bus.avs_read) m_rdata = m_regval(a);
      w1c  = (bus.avs_write && a == 1) ? bus.avs_writedata[NB-1:0] : '0;
      nirq = |(m_edge & m_mask);
      nseg = m_segs();
      m_irq    = nirq;
      m_seg    = nseg;
      m_edge   = (m_edge & ~w1c) | press;
      m_stable = m_stable ^ acc;
      for (int j = 0; j < DC; j++) m_q[j] = m_q[j+1];
      m_q[DC] = button_export;
      if (bus.avs_write) begin
        if (a == 2) m_mask = bus.avs_writedata[NB-1:0];
        if (a == 3) m_mode = bus.avs_writedata[ND-1:0];
        if (a >= 4 && a < 4 + ND) m_dig[a-4] = bus.avs_writedata[7:0];
      end
    end
    #1;
    check("irq", 64'(irq), 64'(m_irq));
    check("seg", 64'(sevseg_export), 64'(m_seg));
    check("rdata", 64'(bus.avs_readdata), 64'(m_rdata));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    tick();
    bus.avs_write     = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    tick();
    bus.avs_read    = 1'b0;
    d = bus.avs_readdata;
  endtask

  logic [31:0] rd;
  logic [NB-1:0] pins;
  int hold [NB];

  initial begin
    reset_reset       = 1'b1;
    bus.avs_address   = '0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    pins              = '1;
    button_export     = pins;
    m_reset();

    // reset state
    ticks(3);
    reset_reset = 1'b0;
    check("rst_seg", 64'(sevseg_export), 64'h3FF_FFFF_FFFF);
    check("rst_irq", 64'(irq), 64'd0);
    bus_rd(4'd0, rd); check("rst_state", 64'(rd), 64'd0);
    bus_rd(4'd1, rd); check("rst_edge", 64'(rd), 64'd0);
    bus_rd(4'd2, rd); check("rst_mask", 64'(rd), 64'd0);

    // clean press on button 2: accepted DC+2 edges after the drive
    pins[2] = 1'b0; button_export = pins;
    ticks(5);
    bus_rd(4'd0, rd); check("press_early", 64'(rd), 64'd0);
    bus_rd(4'd0, rd); check("press_state", 64'(rd), 64'h04);
    bus_rd(4'd1, rd); check("press_edge", 64'(rd), 64'h04);
    check("press_irq", 64'(irq), 64'd0);

    // bounce on button 0 shorter than the debounce window
    for (int k = 0; k < 5; k++) begin
      pins[0] = 1'b0; button_export = pins; ticks(2);
      pins[0] = 1'b1; button_export = pins; ticks(2);
    end
    ticks(8);
    bus_rd(4'd0, rd); check("bounce_state", 64'(rd), 64'h04);
    bus_rd(4'd1, rd); check("bounce_edge", 64'(rd), 64'h04);

    // interrupt and W1C racing a fresh press
    bus_wr(4'd2, 32'h04);
    tick();
    check("irq_on", 64'(irq), 64'd1);
    pins[2] = 1'b1; button_export = pins;
    ticks(8);
    pins[2] = 1'b0; button_export = pins;
    ticks(5);
    bus_wr(4'd1, 32'h04);
    bus_rd(4'd1, rd); check("race_edge", 64'(rd), 64'h04);
    check("race_irq", 64'(irq), 64'd1);
    bus_wr(4'd1, 32'h04);
    check("clr_irq_hold", 64'(irq), 64'd1);
    tick();
    check("clr_irq_drop", 64'(irq), 64'd0);

    // display paths
    bus_wr(4'd4, 32'h0A);
    check("hex_lat", 64'(sevseg_export[6:0]), 64'h7F);
    tick();
    check("hex_a", 64'(sevseg_export[6:0]), 64'h08);
    bus_wr(4'd3, 32'h01);
    bus_wr(4'd4, 32'h49);
    tick();
    check("raw_seg", 64'(sevseg_export[6:0]), 64'h36);
    bus_wr(4'd4, 32'h80);
    tick();
    check("blank_seg", 64'(sevseg_export[6:0]), 64'h7F);

    // readback and out-of-range
    bus_wr(4'd9, 32'h0F);
    bus_rd(4'd9, rd);  check("dig5_rd", 64'(rd), 64'h0F);
    bus_rd(4'd10, rd); check("oor_rd", 64'(rd), 64'd0);
    bus_wr(4'd10, 32'hFFFF_FFFF);
    bus_rd(4'd9, rd);  check("dig5_keep", 64'(rd), 64'h0F);
    bus_rd(4'd10, rd); check("oor_rd2", 64'(rd), 64'd0);
    check("dig5_seg", 64'(sevseg_export[41:35]), 64'h0E);

    // random traffic
    for (int i = 0; i < NB; i++) hold[i] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold[i] == 0) begin
          pins[i] = $urandom_range(0, 1) == 1;
          hold[i] = $urandom_range(1, 10);
        end else begin
          hold[i]--;
        end
      end
      button_export     = pins;
      bus.avs_address   = 4'($urandom_range(0, 15));
      bus.avs_writedata = $urandom;
      bus.avs_read      = $urandom_range(0, 1) == 1;
      bus.avs_write     = $urandom_range(0, 2) == 0;
      reset_reset       = $urandom_range(0, 599) == 0;
      tick();
    end
    reset_reset   = 1'b0;
    bus.avs_read  = 1'b0;
    bus.avs_write = 1'b0;
    ticks(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/button_sevseg_io.md
Name: button_sevseg_io

Overview:
- Parametrised memory-mapped peripheral that replaces the fixed set of per-button and per-display PIO exports on the platform.
- Takes N_BUTTONS raw push-button inputs and conditions each one: 2-flop synchronise, per-channel debounce, press-event capture with maskable interrupt.
- Drives N_DIGITS seven-segment displays from registered digit values, selectable per digit as hex-decoded or raw segments.
- Sits on the Avalon-MM fabric as a slave; the processes on the CPU poll or take interrupts from it.

Parameters:
- N_BUTTONS, 5, number of button channels (1..16).
- N_DIGITS, 6, number of seven-segment digits (1..12).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a level change (>=2).
- BTN_ACTIVE_LOW, 1, 1 = pressed button reads 0 at the pin.
- SEG_ACTIVE_LOW, 1, 1 = a lit segment is driven 0.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- avs_address  in  4  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid 1 cycle after avs_read.
- irq  out  1  level interrupt.
- button_export  in  N_BUTTONS  raw asynchronous button pins.
- sevseg_export  out  7*N_DIGITS  segments; digit i occupies [7i+6:7i], bit order g..a.

Behaviour:
- Reset is synchronous, active-high, and takes priority over everything including bus writes in the same cycle. Reset values:
  - sync flops and stable levels = inactive pin level (1 if BTN_ACTIVE_LOW);
  - debounce counters 0; EDGE 0; MASK 0; MODE 0; digit regs = blank bit set, value 0;
  - avs_readdata 0; irq 0;
  - sevseg_export = all segments off (all 1s if SEG_ACTIVE_LOW).
- Synchroniser: two flops per channel, no reset bypass.
- Debounce, per channel:
  - If sync output != stable level, the counter increments; otherwise the counter clears.
  - When counter == DEBOUNCE_CYCLES-1 and the mismatch persists, stable takes the sync value and the counter clears.
  - Any bounce back clears the counter; a partial count never carries over.
- Press event: stable goes inactive->active, so EDGE[i] sets in the same cycle stable updates. Release events are not captured.
- Latency: pin held from clock edge k gives stable/EDGE updated at edge k+2+DEBOUNCE_CYCLES.
- Register map (word addresses; unused bits read 0, writes ignored):
  - 0 STATE (RO): debounced levels normalised to 1 = pressed.
  - 1 EDGE (RW1C): writing 1 clears a bit. A set and a clear on the same bit in the same cycle leave it set (set wins).
  - 2 MASK (RW): interrupt enables, [N_BUTTONS-1:0].
  - 3 MODE (RW): bit i = 1 makes digit i raw, 0 makes it hex.
  - 4..4+N_DIGITS-1 DIGITi (RW):
    - bit 7 = blank;
    - hex mode: bits [3:0] = value 0..F;
    - raw mode: bits [6:0] = segments g..a, 1 = lit (polarity applied at output).
  - Addresses above the last digit read 0; writes to them are ignored.
- irq = registered OR of (EDGE & MASK); it asserts 1 cycle after the causing EDGE/MASK change and drops 1 cycle after it is cleared.
- Read: avs_readdata is registered from address at the read edge, so it is valid the next cycle. It holds its value when no read is issued. A read and a write at the same address in the same cycle return the old value.
- Display:
  - A write at edge k updates the digit register at k.
  - sevseg_export is registered from decode and shows the new pattern after edge k+1.
  - Blank overrides mode: all segments off.
  - Hex font (lit segments): 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71.
  - Output = font, inverted when SEG_ACTIVE_LOW.
- Reset mid-debounce discards the partial count. Reset while irq is high drops irq at the next edge.

Test Plan:
- Reset check (DEBOUNCE_CYCLES=4): hold reset 3 cycles, then release -> sevseg_export all 1s, irq 0, reads of STATE/EDGE/MASK return 0.
- Clean press: drive button_export[2] to 0 at edge k and hold -> STATE=0x04 and EDGE=0x04 at edge k+6, irq stays 0 (MASK=0).
- Bounce rejection: toggle button_export[0] 0/1 every 2 cycles for 20 cycles, then hold 1 -> STATE and EDGE unchanged (0).
- Interrupt with W1C race: write MASK=0x04, press button 2 -> irq=1. Write EDGE=0x04 in the same cycle as a new press event on button 2 -> EDGE stays 0x04, irq stays 1. Write EDGE=0x04 again with no event -> irq=0 one cycle later.
- Display:
  - write DIGIT0=0x0A in hex mode -> sevseg_export[6:0]=0x08 two edges after the write;
  - write MODE=0x01, DIGIT0=0x49 -> segments [6:0]=0x36;
  - write DIGIT0=0x80 -> 0x7F.
- Readback/out-of-range: write DIGIT5=0x0F, read address 9 -> readdata 0x0F on the next cycle. Read address 10 -> 0. A write to 10 changes nothing.
